// File: rtl/freq_band_classifier.sv
// Moving-average smoother and debounced beacon-band classifier for the kHz window count.
// Two-stage pipeline: stage 1 updates the sample window and running sum, stage 2 classifies and debounces.
module freq_band_classifier #(
  parameter int W        = 32,
  parameter int AVG_LOG2 = 2,
  parameter int A_LO     = 900,
  parameter int A_HI     = 1100,
  parameter int B_LO     = 9000,
  parameter int B_HI     = 11000,
  parameter int CONFIRM  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] freq,
  input  logic         freq_valid,
  output logic [W-1:0] avg_freq,
  output logic [1:0]   class_out,
  output logic         class_valid,
  output logic         class_chg
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = W + AVG_LOG2;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int CW    = $clog2(CONFIRM + 1);

  localparam logic [W-1:0]  A_LO_W   = W'(A_LO);
  localparam logic [W-1:0]  A_HI_W   = W'(A_HI);
  localparam logic [W-1:0]  B_LO_W   = W'(B_LO);
  localparam logic [W-1:0]  B_HI_W   = W'(B_HI);
  localparam logic [FW-1:0] DEPTH_F  = FW'(DEPTH);
  localparam logic [CW-1:0] CONFIRM_C = CW'(CONFIRM);
  localparam logic [CW-1:0] ONE_C     = CW'(1);

  localparam logic [1:0] BAND_NONE = 2'b00;
  localparam logic [1:0] BAND_A    = 2'b01;
  localparam logic [1:0] BAND_B    = 2'b10;

  typedef enum logic [1:0] {WARMUP, PENDING, HOLD} state_t;

  logic [W-1:0]  window_reg [DEPTH];
  logic [SW-1:0] sum_reg;
  logic [FW-1:0] fill_reg;
  logic          s1_valid_reg;

  state_t        state_reg, state_next;
  logic [1:0]    cand_reg, cand_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          commit;

  logic [W-1:0]  avg_reg, avg_next;
  logic [1:0]    class_reg, class_next;
  logic          valid_reg, valid_next;
  logic          chg_reg, chg_next;

  logic [W-1:0]  avg_now;
  logic [1:0]    band_now;
  logic          full_now;
  logic [CW-1:0] cnt_inc;

  // Stage 1: sample window as a shift register, oldest sample at the far end.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_window
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          window_reg[gi] <= '0;
        end else if (freq_valid) begin
          if (gi == 0) window_reg[gi] <= freq;
          else         window_reg[gi] <= window_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  // Modular SW-bit arithmetic keeps the final sum exact even if sum+freq wraps transiently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_reg      <= '0;
      fill_reg     <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= freq_valid;
      if (freq_valid) begin
        sum_reg <= sum_reg + SW'(freq) - SW'(window_reg[DEPTH-1]);
        if (fill_reg != DEPTH_F) fill_reg <= fill_reg + FW'(1);
      end
    end
  end

  assign avg_now  = sum_reg[SW-1:AVG_LOG2];
  assign full_now = (fill_reg == DEPTH_F);
  assign cnt_inc  = cnt_reg + ONE_C;

  always_comb begin
    band_now = BAND_NONE;
    if (avg_now >= A_LO_W && avg_now <= A_HI_W)      band_now = BAND_A;
    else if (avg_now >= B_LO_W && avg_now <= B_HI_W) band_now = BAND_B;
  end

  // Debounce FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= WARMUP;
      cand_reg  <= BAND_NONE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Debounce FSM: next state, candidate and confirm count.
  always_comb begin
    state_next = state_reg;
    cand_next  = cand_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    if (s1_valid_reg) begin
      case (state_reg)
        WARMUP: begin
          if (full_now) begin
            cand_next = band_now;
            cnt_next  = ONE_C;
            if (CONFIRM == 1) begin
              commit     = 1'b1;
              state_next = HOLD;
            end else begin
              state_next = PENDING;
            end
          end
        end
        PENDING: begin
          if (band_now == cand_reg) begin
            if (cnt_inc >= CONFIRM_C) begin
              cnt_next   = CONFIRM_C;
              commit     = 1'b1;
              state_next = HOLD;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            cand_next = band_now;
            cnt_next  = ONE_C;
            if (CONFIRM == 1) begin
              commit     = 1'b1;
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (band_now != class_reg) begin
            cand_next = band_now;
            cnt_next  = ONE_C;
            if (CONFIRM == 1) commit = 1'b1;
            else              state_next = PENDING;
          end
        end
        default: state_next = WARMUP;
      endcase
    end
  end

  // Debounce FSM: output decode. A commit pulses class_chg only on a real change or the first commit.
  always_comb begin
    avg_next   = s1_valid_reg ? avg_now : avg_reg;
    class_next = commit ? cand_next : class_reg;
    valid_next = valid_reg | commit;
    chg_next   = commit && (!valid_reg || (cand_next != class_reg));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avg_reg   <= '0;
      class_reg <= BAND_NONE;
      valid_reg <= 1'b0;
      chg_reg   <= 1'b0;
    end else begin
      avg_reg   <= avg_next;
      class_reg <= class_next;
      valid_reg <= valid_next;
      chg_reg   <= chg_next;
    end
  end

  assign avg_freq    = avg_reg;
  assign class_out   = class_reg;
  assign class_valid = valid_reg;
  assign class_chg   = chg_reg;
endmodule

// File: tb/tb_freq_band_classifier.sv
// Bench for freq_band_classifier: directed scenarios plus random band-hopping traffic,
// checked every cycle against a window-queue / run-length reference model.
module tb_freq_band_classifier;
  localparam int W       = 32;
  localparam int DEPTH   = 4;
  localparam int CONFIRM = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] freq;
  logic         freq_valid;
  logic [W-1:0] avg_freq;
  logic [1:0]   class_out;
  logic         class_valid;
  logic         class_chg;

  freq_band_classifier #(
    .W(W), .AVG_LOG2(2), .A_LO(900), .A_HI(1100),
    .B_LO(9000), .B_HI(11000), .CONFIRM(CONFIRM)
  ) dut (
    .clk(clk), .rst(rst), .freq(freq), .freq_valid(freq_valid),
    .avg_freq(avg_freq), .class_out(class_out),
    .class_valid(class_valid), .class_chg(class_chg)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: last DEPTH samples in a queue; a band is committed when the run of
  // identical full-window bands reaches exactly CONFIRM.
  longint unsigned hist[$];
  int              nsamp;
  bit              pend;
  bit              pend_full;
  longint unsigned pend_avg;
  longint unsigned exp_avg;
  int              exp_class;
  bit              exp_valid;
  bit              exp_chg;
  int              last_band;
  int              run_len;

  function automatic int band_of(input longint unsigned a);
    if (a >= 900 && a <= 1100)        return 1;
    else if (a >= 9000 && a <= 11000) return 2;
    else                              return 0;
  endfunction

  task automatic model_reset();
    hist.delete();
    nsamp = 0; pend = 0; pend_full = 0; pend_avg = 0;
    exp_avg = 0; exp_class = 0; exp_valid = 0; exp_chg = 0;
    last_band = 0; run_len = 0;
  endtask

  task automatic model_stage2();
    int b;
    if (!pend) return;
    pend    = 0;
    exp_avg = pend_avg;
    if (pend_full) begin
      b = band_of(pend_avg);
      if (run_len > 0 && b == last_band) run_len++;
      else begin
        last_band = b;
        run_len   = 1;
      end
      if (run_len == CONFIRM) begin
        exp_chg   = !exp_valid || (b != exp_class);
        exp_class = b;
        exp_valid = 1;
      end
    end
    $display("sample avg=%0d class=%0d valid=%0d chg=%0d", exp_avg, exp_class, exp_valid, exp_chg);
  endtask

  task automatic check_outputs();
    check("avg_freq", avg_freq, exp_avg);
    check("class_out", class_out, exp_class);
    check("class_valid", class_valid, exp_valid);
    check("class_chg", class_chg, exp_chg);
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic step(input bit v, input logic [W-1:0] f);
    longint unsigned s;
    freq_valid = v;
    freq       = v ? f : W'($urandom);
    @(posedge clk);
    #1;
    exp_chg = 0;
    model_stage2();
    if (v) begin
      hist.push_back(longint'(f));
      if (hist.size() > DEPTH) void'(hist.pop_front());
      nsamp++;
      s = 0;
      foreach (hist[i]) s += hist[i];
      pend_avg  = s / DEPTH;
      pend_full = (nsamp >= DEPTH);
      pend      = 1;
    end
    check_outputs();
    @(negedge clk);
    freq_valid = 1'b0;
  endtask

  // Asynchronous reset raised mid-cycle; outputs must clear before the next edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_avg", avg_freq, 0);
    check("rst_class", class_out, 0);
    check("rst_valid", class_valid, 0);
    check("rst_chg", class_chg, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic burst(input int n, input logic [W-1:0] f, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, f);
      for (int g = 0; g < gap; g++) step(1'b0, '0);
    end
  endtask

  logic [W-1:0] bases [12] = '{1000, 900, 1100, 899, 1101, 10000,
                               9000, 11000, 8999, 11001, 50000, 0};

  initial begin
    logic [W-1:0] base;
    logic [W-1:0] f;
    model_reset();
    rst = 1'b1; freq_valid = 1'b0; freq = '0;
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    burst(8, 1000, 1);          // steady band A, commit after fill + 2
    step(1'b0, '0);
    burst(8, 10000, 0);         // cross into band B
    step(1'b0, '0);
    burst(8, 1000, 2);          // relock A
    burst(1, 1500, 1);          // short excursion out of A
    burst(1, 500, 1);
    burst(6, 1000, 1);
    burst(1, 50000, 0);         // large outlier lingers for a full window
    burst(6, 1000, 0);
    burst(12, 1100, 0);         // inclusive upper bound, back-to-back
    step(1'b0, '0);

    burst(2, 1000, 0);          // reset with a sample in flight
    do_reset();
    burst(3, 1000, 0);
    step(1'b0, '0);

    do_reset();
    burst(6, {W{1'b1}}, 0);     // full-scale input, no sum overflow, NONE committed
    step(1'b0, '0);
    step(1'b0, '0);

    base = bases[0];
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 14) == 0) base = bases[$urandom_range(0, 11)];
      f = base + W'($urandom_range(0, 60)) - W'(30);
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 2) != 0, f);
    end
    step(1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
